// File: rtl/inst_buffer_mw.sv
// Multi-width instruction buffer between predecode and decode.
// Compacts sparse fetch lanes into a circular queue and hands in-order groups to decode.
module inst_buffer_mw #(
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned IN_WIDTH  = 8,
  parameter int unsigned OUT_WIDTH = 4,
  parameter int unsigned INST_W    = 32,
  parameter int unsigned FSQ_W     = 5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic [IN_WIDTH-1:0]            in_en,
  input  logic [IN_WIDTH*INST_W-1:0]     in_inst,
  input  logic [FSQ_W-1:0]               in_fsqIdx,
  output logic                           in_ready,
  output logic [OUT_WIDTH-1:0]           out_en,
  output logic [OUT_WIDTH*INST_W-1:0]    out_inst,
  output logic [OUT_WIDTH*FSQ_W-1:0]     out_fsqIdx,
  input  logic                           out_stall,
  input  logic                           flush,
  output logic [$clog2(DEPTH):0]         count,
  output logic                           full
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = IDX_W + 1;

  logic [CNT_W-1:0]  r_head;
  logic [CNT_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic [INST_W-1:0] r_inst [DEPTH];
  logic [FSQ_W-1:0]  r_fsq  [DEPTH];

  logic [CNT_W-1:0]  w_free;
  logic [CNT_W-1:0]  w_n_in;
  logic [CNT_W-1:0]  w_n_avail;
  logic [CNT_W-1:0]  w_n_deq;
  logic [IDX_W-1:0]  w_off    [IN_WIDTH];
  logic [IDX_W-1:0]  w_wr_idx [IN_WIDTH];
  logic [IDX_W-1:0]  w_rd_idx [OUT_WIDTH];
  logic              w_enq;
  logic              w_deq;

  // Space check uses the registered count only, so in_ready has no input path.
  assign w_free   = CNT_W'(DEPTH) - r_count;
  assign in_ready = (w_free >= CNT_W'(IN_WIDTH));
  assign full     = ~in_ready;
  assign count    = r_count;

  assign w_enq     = in_valid && in_ready && !flush;
  assign w_deq     = !out_stall && !flush;
  assign w_n_avail = (r_count < CNT_W'(OUT_WIDTH)) ? r_count : CNT_W'(OUT_WIDTH);
  assign w_n_deq   = w_deq ? w_n_avail : '0;

  // Running prefix count of enabled lanes gives each lane its compacted slot.
  always_comb begin
    w_n_in = '0;
    for (int unsigned i = 0; i < IN_WIDTH; i++) begin
      w_off[i]    = w_n_in[IDX_W-1:0];
      w_wr_idx[i] = r_tail[IDX_W-1:0] + w_off[i];
      w_n_in      = w_n_in + CNT_W'(in_en[i]);
    end
  end

  always_comb begin
    out_en     = '0;
    out_inst   = '0;
    out_fsqIdx = '0;
    for (int unsigned i = 0; i < OUT_WIDTH; i++) begin
      w_rd_idx[i]                   = r_head[IDX_W-1:0] + IDX_W'(i);
      out_en[i]                     = (CNT_W'(i) < w_n_avail) && !flush;
      out_inst[i*INST_W +: INST_W]  = r_inst[w_rd_idx[i]];
      out_fsqIdx[i*FSQ_W +: FSQ_W]  = r_fsq[w_rd_idx[i]];
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      for (int unsigned i = 0; i < IN_WIDTH; i++) begin
        if (in_en[i]) begin
          r_inst[w_wr_idx[i]] <= in_inst[i*INST_W +: INST_W];
          r_fsq[w_wr_idx[i]]  <= in_fsqIdx;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + w_n_deq;
      r_tail  <= r_tail + (w_enq ? w_n_in : '0);
      r_count <= r_count + (w_enq ? w_n_in : '0) - w_n_deq;
    end
  end

endmodule
